// File: rtl/video_timing_pattern_gen.sv
// Video timing generator: pixel enable, H/V counters, blank/sync/DE flags and a
// selectable RGB test pattern, all outputs one pixel behind the internal counters.
module video_timing_pattern_gen #(
  parameter int H_TOTAL       = 638,
  parameter int H_BLANK_START = 529,
  parameter int H_SYNC_START  = 544,
  parameter int H_SYNC_END    = 590,
  parameter int COLOR_W       = 8,
  parameter int FRAME_W       = 16,
  parameter int SCROLL_STEP   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pal,
  input  logic                   scandouble,
  input  logic [2:0]             pattern,
  input  logic                   scroll_en,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   ce_pix,
  output logic [9:0]             hcount,
  output logic [9:0]             vcount,
  output logic [FRAME_W-1:0]     frame,
  output logic                   HBlank,
  output logic                   HSync,
  output logic                   VBlank,
  output logic                   VSync,
  output logic                   de,
  output logic [3*COLOR_W-1:0]   video
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] HBS    = 10'(H_BLANK_START);
  localparam logic [9:0] HSS    = 10'(H_SYNC_START);
  localparam logic [9:0] HSE    = 10'(H_SYNC_END);
  localparam int RAMP_UP = (COLOR_W >= 8) ? COLOR_W - 8 : 0;
  localparam int RAMP_DN = (COLOR_W < 8) ? 8 - COLOR_W : 0;
  localparam logic [COLOR_W-1:0] ZERO = '0;
  localparam logic [COLOR_W-1:0] FULL = '1;
  localparam logic [COLOR_W-1:0] MID  = {1'b1, {(COLOR_W-1){1'b0}}};

  logic                 r_ce;
  logic [9:0]           r_hc;
  logic [9:0]           r_vc;
  logic [9:0]           r_scroll;
  logic [FRAME_W-1:0]   r_frame;
  logic                 r_mode_pal;
  logic                 r_mode_sd;
  logic [2:0]           r_mode_pat;
  logic [9:0]           r_hcount;
  logic [9:0]           r_vcount;
  logic                 r_hblank;
  logic                 r_hsync;
  logic                 r_vblank;
  logic                 r_vsync;
  logic                 r_de;
  logic [3*COLOR_W-1:0] r_video;

  logic [9:0]           w_vlast;
  logic [9:0]           w_vb_set;
  logic [9:0]           w_vs_set;
  logic [9:0]           w_vs_clr;
  logic                 w_line_end;
  logic                 w_frame_end;
  logic                 w_hblank_nx;
  logic                 w_hsync_nx;
  logic                 w_vblank_nx;
  logic                 w_vsync_nx;
  logic                 w_de_nx;
  logic [7:0]           w_gsum;
  logic [COLOR_W-1:0]   w_ramp;
  logic [COLOR_W-1:0]   w_grey;
  logic [2:0]           w_bar;
  logic [3*COLOR_W-1:0] w_pix;

  // Left-justify an 8-bit ramp value into a COLOR_W channel.
  function automatic logic [COLOR_W-1:0] rampOf(input logic [7:0] v);
    return COLOR_W'((18'(v) << RAMP_UP) >> RAMP_DN);
  endfunction

  always_comb begin
    case ({r_mode_pal, r_mode_sd})
      2'b00: begin
        w_vlast = 10'd261; w_vb_set = 10'd240; w_vs_set = 10'd245; w_vs_clr = 10'd248;
      end
      2'b01: begin
        w_vlast = 10'd523; w_vb_set = 10'd480; w_vs_set = 10'd490; w_vs_clr = 10'd496;
      end
      2'b10: begin
        w_vlast = 10'd311; w_vb_set = 10'd300; w_vs_set = 10'd304; w_vs_clr = 10'd308;
      end
      default: begin
        w_vlast = 10'd623; w_vb_set = 10'd601; w_vs_set = 10'd609; w_vs_clr = 10'd617;
      end
    endcase
  end

  assign w_line_end  = (r_hc == H_LAST);
  assign w_frame_end = w_line_end && (r_vc == w_vlast);

  // Vertical flags only move at the HSync column; a set wins over a clear.
  assign w_hblank_nx = (r_hc == HBS) ? 1'b1 : (r_hc == 10'd0) ? 1'b0 : r_hblank;
  assign w_hsync_nx  = (r_hc == HSS) ? 1'b1 : (r_hc == HSE) ? 1'b0 : r_hsync;
  assign w_vblank_nx = (r_hc != HSS) ? r_vblank :
                       (r_vc == w_vb_set) ? 1'b1 : (r_vc == 10'd0) ? 1'b0 : r_vblank;
  assign w_vsync_nx  = (r_hc != HSS) ? r_vsync :
                       (r_vc == w_vs_set) ? 1'b1 : (r_vc == w_vs_clr) ? 1'b0 : r_vsync;
  assign w_de_nx     = ~w_hblank_nx & ~w_vblank_nx;

  assign w_gsum = r_hc[7:0] + r_scroll[7:0];
  assign w_ramp = rampOf(r_hc[7:0]);
  assign w_grey = rampOf(w_gsum);

  always_comb begin
    w_pix = '0;
    w_bar = 3'b000;
    case (r_hc[8:6])
      3'd0:    w_bar = 3'b111;
      3'd1:    w_bar = 3'b110;
      3'd2:    w_bar = 3'b011;
      3'd3:    w_bar = 3'b010;
      3'd4:    w_bar = 3'b101;
      3'd5:    w_bar = 3'b100;
      3'd6:    w_bar = 3'b001;
      default: w_bar = 3'b000;
    endcase
    case (r_mode_pat)
      3'd0: begin
        case (r_vc[4:2])
          3'd0:    w_pix = {w_ramp, ZERO, ZERO};
          3'd1:    w_pix = {ZERO, w_ramp, ZERO};
          3'd2:    w_pix = {ZERO, ZERO, w_ramp};
          3'd3:    w_pix = {w_ramp, w_ramp, w_ramp};
          default: w_pix = {MID, MID, MID};
        endcase
      end
      3'd1:    w_pix = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
      3'd2:    w_pix = (r_hc[4] ^ r_vc[4]) ? {FULL, FULL, FULL} : '0;
      3'd3:    w_pix = solid_rgb;
      3'd4:    w_pix = {w_grey, w_grey, w_grey};
      default: w_pix = '0;
    endcase
  end

  // Mode inputs are sampled only at the last pixel of a frame so a frame is never mixed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ce       <= 1'b0;
      r_hc       <= '0;
      r_vc       <= '0;
      r_frame    <= '0;
      r_scroll   <= '0;
      r_mode_pal <= pal;
      r_mode_sd  <= scandouble;
      r_mode_pat <= pattern;
    end else begin
      r_ce <= r_mode_sd ? 1'b1 : ~r_ce;
      if (r_ce) begin
        if (w_line_end) begin
          r_hc <= '0;
          if (w_frame_end) begin
            r_vc       <= '0;
            r_frame    <= r_frame + FRAME_W'(1);
            r_mode_pal <= pal;
            r_mode_sd  <= scandouble;
            r_mode_pat <= pattern;
            if (scroll_en) r_scroll <= r_scroll + 10'(SCROLL_STEP);
          end else begin
            r_vc <= r_vc + 10'd1;
          end
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hblank <= 1'b0;
      r_hsync  <= 1'b0;
      r_vblank <= 1'b0;
      r_vsync  <= 1'b0;
      r_de     <= 1'b0;
      r_video  <= '0;
    end else if (r_ce) begin
      r_hcount <= r_hc;
      r_vcount <= r_vc;
      r_hblank <= w_hblank_nx;
      r_hsync  <= w_hsync_nx;
      r_vblank <= w_vblank_nx;
      r_vsync  <= w_vsync_nx;
      r_de     <= w_de_nx;
      r_video  <= w_de_nx ? w_pix : '0;
    end
  end

  assign ce_pix = r_ce;
  assign hcount = r_hcount;
  assign vcount = r_vcount;
  assign frame  = r_frame;
  assign HBlank = r_hblank;
  assign HSync  = r_hsync;
  assign VBlank = r_vblank;
  assign VSync  = r_vsync;
  assign de     = r_de;
  assign video  = r_video;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench: a short-line instance for frame-level timing and a full-width 10-bit
// instance for bar/ramp colours; a scoreboard matches pixels by (hcount, vcount, frame).
module tb_video_timing_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pal;
  logic        scandouble;
  logic [2:0]  pattern;
  logic        scroll_en;
  logic [23:0] solidS;
  logic [29:0] solidW;

  logic        ceS, HBlankS, HSyncS, VBlankS, VSyncS, deS;
  logic [9:0]  hcountS, vcountS;
  logic [15:0] frameS;
  logic [23:0] videoS;

  logic        ceW, HBlankW, HSyncW, VBlankW, VSyncW, deW;
  logic [9:0]  hcountW, vcountW;
  logic [15:0] frameW;
  logic [29:0] videoW;

  video_timing_pattern_gen #(
    .H_TOTAL(12), .H_BLANK_START(8), .H_SYNC_START(9), .H_SYNC_END(11),
    .COLOR_W(8), .FRAME_W(16), .SCROLL_STEP(6)
  ) dutS (
    .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble), .pattern(pattern),
    .scroll_en(scroll_en), .solid_rgb(solidS), .ce_pix(ceS), .hcount(hcountS),
    .vcount(vcountS), .frame(frameS), .HBlank(HBlankS), .HSync(HSyncS),
    .VBlank(VBlankS), .VSync(VSyncS), .de(deS), .video(videoS)
  );

  video_timing_pattern_gen #(
    .COLOR_W(10)
  ) dutW (
    .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble), .pattern(pattern),
    .scroll_en(scroll_en), .solid_rgb(solidW), .ce_pix(ceW), .hcount(hcountW),
    .vcount(vcountW), .frame(frameW), .HBlank(HBlankW), .HSync(HSyncW),
    .VBlank(VBlankW), .VSync(VSyncW), .de(deW), .video(videoW)
  );

  typedef struct {
    string       name;
    bit          wide;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [15:0] fr;
    logic [29:0] video;
    logic [4:0]  flags;
  } expect_t;

  expect_t sbQ[$];
  int compareCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Flags are packed {HBlank, HSync, VBlank, VSync, de}.
  task automatic expectPixel(input string name, input bit wide, input int hc, input int vc,
                             input int fr, input logic [29:0] video, input logic [4:0] flags);
    expect_t e;
    e.name = name; e.wide = wide;
    e.hc = 10'(hc); e.vc = 10'(vc); e.fr = 16'(fr);
    e.video = video; e.flags = flags;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic palV, input logic sdV, input logic [2:0] patV,
                               input logic scrV, input logic [23:0] solidV, input int hold);
    @(negedge clk);
    pal = palV; scandouble = sdV; pattern = patV; scroll_en = scrV; solidS = solidV;
    reset = 1'b1;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sbQ.size() != 0; i++) @(negedge clk);
    while (sbQ.size() != 0) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL %s: pixel never presented, expected hc=%0d vc=%0d frame=%0d",
               sbQ[0].name, sbQ[0].hc, sbQ[0].vc, sbQ[0].fr);
      void'(sbQ.pop_front());
    end
  endtask

  logic        mCe;
  logic [9:0]  mHc, mVc;
  logic [15:0] mFr;
  logic [29:0] mVideo;
  logic [4:0]  mFlags;
  expect_t     mHead;

  // Monitor: each pixel is presented during exactly one ce_pix-high cycle.
  always @(negedge clk) begin
    if (sbQ.size() != 0) begin
      mHead  = sbQ[0];
      mCe    = mHead.wide ? ceW : ceS;
      mHc    = mHead.wide ? hcountW : hcountS;
      mVc    = mHead.wide ? vcountW : vcountS;
      mFr    = mHead.wide ? frameW : frameS;
      mVideo = mHead.wide ? videoW : {6'b0, videoS};
      mFlags = mHead.wide ? {HBlankW, HSyncW, VBlankW, VSyncW, deW}
                          : {HBlankS, HSyncS, VBlankS, VSyncS, deS};
      if (mCe && mHc == mHead.hc && mVc == mHead.vc && mFr == mHead.fr) begin
        checkOutput({mHead.name, ".video"}, 64'(mVideo), 64'(mHead.video));
        checkOutput({mHead.name, ".flags"}, 64'(mFlags), 64'(mHead.flags));
        void'(sbQ.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; pal = 1'b0; scandouble = 1'b0; pattern = 3'd0; scroll_en = 1'b0;
    solidS = '0; solidW = '0;
    repeat (5) @(negedge clk);
    checkOutput("rstS.count", {ceS, hcountS, vcountS, frameS}, 64'd0);
    checkOutput("rstS.out", {HBlankS, HSyncS, VBlankS, VSyncS, deS, videoS}, 64'd0);
    checkOutput("rstW.count", {ceW, hcountW, vcountW, frameW}, 64'd0);
    checkOutput("rstW.out", {HBlankW, HSyncW, VBlankW, VSyncW, deW, videoW}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ceAlt%0d", i), 64'(ceS), 64'((i % 2) == 0));
    end

    // NTSC, pattern 0: red ramp on both colour depths.
    expectPixel("a.redRampS", 1'b0, 5, 1, 0, 30'h050000, 5'b00001);
    expectPixel("a.redRampW", 1'b1, 128, 0, 0, 30'h20000000, 5'b00001);
    waitDrain(2000);

    // Reset in the middle of a line clears everything on the next clock.
    pattern = 3'd1;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstS.count", {ceS, hcountS, vcountS, frameS}, 64'd0);
    checkOutput("midRstS.out", {HBlankS, HSyncS, VBlankS, VSyncS, deS, videoS}, 64'd0);
    checkOutput("midRstW.count", {ceW, hcountW, vcountW, frameW}, 64'd0);
    checkOutput("midRstW.out", {HBlankW, HSyncW, VBlankW, VSyncW, deW, videoW}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Colour bars and horizontal blanking; then the first frame wrap.
    expectPixel("b.whiteS", 1'b0, 2, 3, 0, 30'hFFFFFF, 5'b00001);
    expectPixel("b.yellowW", 1'b1, 64, 0, 0, 30'h3FFFFC00, 5'b00001);
    expectPixel("b.blueW", 1'b1, 384, 0, 0, 30'h000003FF, 5'b00001);
    expectPixel("b.blackW", 1'b1, 448, 0, 0, 30'h0, 5'b00001);
    expectPixel("b.hblankW", 1'b1, 529, 0, 0, 30'h0, 5'b10000);
    expectPixel("b.hsyncOnW", 1'b1, 544, 0, 0, 30'h0, 5'b11000);
    expectPixel("b.hsyncOffW", 1'b1, 590, 0, 0, 30'h0, 5'b10000);
    expectPixel("b.lineEndW", 1'b1, 637, 0, 0, 30'h0, 5'b10000);
    expectPixel("b.frame1S", 1'b0, 3, 0, 1, 30'h0, 5'b00100);
    waitDrain(10000);

    // Scrolling grey ramp.
    applyStimulus(1'b0, 1'b0, 3'd4, 1'b1, 24'h0, 3);
    expectPixel("c.scroll6", 1'b0, 0, 1, 1, 30'h060606, 5'b00001);
    expectPixel("c.scroll18", 1'b0, 0, 1, 3, 30'h121212, 5'b00001);
    waitDrain(25000);

    // PAL scandouble vertical timing with checkerboard.
    applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 24'h0, 3);
    expectPixel("d.checkBlack", 1'b0, 0, 15, 0, 30'h0, 5'b00001);
    expectPixel("d.checkWhite", 1'b0, 0, 16, 0, 30'hFFFFFF, 5'b00001);
    expectPixel("d.preVblank", 1'b0, 8, 601, 0, 30'h0, 5'b10000);
    expectPixel("d.vblankOn", 1'b0, 9, 601, 0, 30'h0, 5'b11100);
    expectPixel("d.preVsync", 1'b0, 8, 609, 0, 30'h0, 5'b10100);
    expectPixel("d.vsyncOn", 1'b0, 9, 609, 0, 30'h0, 5'b11110);
    expectPixel("d.vsyncHeld", 1'b0, 8, 617, 0, 30'h0, 5'b10110);
    expectPixel("d.vsyncOff", 1'b0, 9, 617, 0, 30'h0, 5'b11100);
    expectPixel("d.lastLine", 1'b0, 0, 623, 0, 30'h0, 5'b00100);
    expectPixel("d.wrap", 1'b0, 3, 0, 1, 30'h0, 5'b00100);
    waitDrain(12000);

    // Switching to PAL mid-frame only takes effect from the next frame.
    applyStimulus(1'b0, 1'b0, 3'd3, 1'b0, 24'h123456, 3);
    expectPixel("e.solid", 1'b0, 1, 120, 0, 30'h123456, 5'b00001);
    expectPixel("e.ntscVblank", 1'b0, 9, 240, 0, 30'h0, 5'b11100);
    expectPixel("e.ntscLast", 1'b0, 9, 261, 0, 30'h0, 5'b11100);
    expectPixel("e.palNo240", 1'b0, 9, 240, 1, 30'h0, 5'b11000);
    expectPixel("e.palVblank", 1'b0, 9, 300, 1, 30'h0, 5'b11100);
    expectPixel("e.palVsync", 1'b0, 9, 304, 1, 30'h0, 5'b11110);
    expectPixel("e.palLast", 1'b0, 0, 311, 1, 30'h0, 5'b00100);
    expectPixel("e.frame2", 1'b0, 5, 0, 2, 30'h0, 5'b00100);
    for (int i = 0; i < 10000 && vcountS != 10'd100; i++) @(negedge clk);
    checkOutput("e.reachV100", 64'(vcountS), 64'd100);
    pal = 1'b1;
    waitDrain(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
